// File: rtl/flac_pkg.sv
// Shared FLAC header sequencer types, constants and UTF-8 frame number helpers.
package flac_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC0,
        S_SYNC1,
        S_BSSR,
        S_CHSS,
        S_FNUM,
        S_CRC8,
        S_CHPAR,
        S_SUBHDR,
        S_WARMUP,
        S_PRSH,
        S_COEF,
        S_NEXT,
        S_DONE
    } state_e;

    localparam logic [7:0]  CRC8_POLY  = 8'h07;
    localparam logic [15:0] SYNC_WORD  = 16'hFFF8;
    localparam logic [7:0]  FIXED0_HDR = 8'h10;
    localparam logic [5:0]  BYTE_LEN   = 6'd8;
    localparam logic [5:0]  PRSH_LEN   = 6'd9;

    function automatic logic [2:0] utf8_nbytes(input logic [30:0] n);
        if (n < 31'h80)             return 3'd1;
        else if (n < 31'h800)       return 3'd2;
        else if (n < 31'h1_0000)    return 3'd3;
        else if (n < 31'h20_0000)   return 3'd4;
        else if (n < 31'h400_0000)  return 3'd5;
        else                        return 3'd6;
    endfunction

    // Byte k of an nb-byte encoding; lead byte carries nb ones then a zero.
    function automatic logic [7:0] utf8_byte(input logic [30:0] n,
                                             input logic [2:0]  nb,
                                             input logic [2:0]  k);
        logic [30:0] t;
        logic [15:0] pre;
        int          sh;
        sh  = 6 * (int'(nb) - 1 - int'(k));
        t   = n >> sh;
        pre = 16'hFF00 >> nb;
        if (nb == 3'd1)
            return n[7:0];
        else if (k == 3'd0)
            return pre[7:0] | t[7:0];
        else
            return {2'b10, t[5:0]};
    endfunction

endpackage

// File: rtl/flac_crc8.sv
// Byte-wide CRC-8 step (poly 0x07, MSB first) for the frame header bytes.
module flac_crc8
    import flac_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ byte_in;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/flac_header_sequencer.sv
// FLAC frame header plus per-channel LPC/FIXED subframe header field sequencer.
module flac_header_sequencer
    import flac_pkg::*;
#(
    parameter int NCHAN     = 2,
    parameter int SAMPLE_W  = 16,
    parameter int MAX_ORDER = 32,
    parameter int COEF_W    = 15,
    parameter int FIELD_W   = 32
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iStart,
    input  logic [30:0]         iFrameNum,
    input  logic [3:0]          iBsCode,
    input  logic [3:0]          iSrCode,
    input  logic [3:0]          iChanAssign,
    input  logic [2:0]          iSsCode,
    input  logic                iChanValid,
    output logic                oChanReady,
    input  logic [5:0]          iOrder,
    input  logic [3:0]          iPrecision,
    input  logic [4:0]          iShift,
    input  logic [SAMPLE_W-1:0] iData,
    input  logic                iDataValid,
    output logic                oDataReady,
    output logic [FIELD_W-1:0]  oField,
    output logic [5:0]          oFieldLen,
    output logic                oFieldValid,
    input  logic                iFieldReady,
    output logic                oSubDone,
    output logic                oFrameDone,
    output logic                oError,
    output logic                oBusy
);

    localparam logic [5:0] MAXO   = 6'(MAX_ORDER);
    localparam logic [3:0] MAXP   = 4'(COEF_W);
    localparam logic [5:0] SW_LEN = 6'(SAMPLE_W);
    localparam logic [3:0] LASTCH = 4'(NCHAN - 1);
    localparam int         CW     = (COEF_W < SAMPLE_W) ? COEF_W : SAMPLE_W;

    state_e               state_q;
    logic [30:0]          fnum_q;
    logic [3:0]           bs_q, sr_q, ca_q;
    logic [2:0]           ss_q;
    logic [2:0]           nb_q, fidx_q;
    logic [7:0]           crc_q, crc_d;
    logic [5:0]           ord_q, sidx_q;
    logic [3:0]           prec_q;
    logic [4:0]           shift_q;
    logic [3:0]           chan_q;
    logic [FIELD_W-1:0]   field_q, field_d;
    logic [5:0]           len_q, len_d;
    logic                 fvalid_q, subdone_q, framedone_q, err_q, busy_q;

    logic                 ld, emit;
    logic [7:0]           hdr_byte, sub_hdr;
    logic [4:0]           m1;
    logic [8:0]           prsh;
    logic [FIELD_W-1:0]   coef_v;
    logic [5:0]           ord_c;
    logic [3:0]           prec_c;
    logic                 bad_par;

    // Output register is loadable when empty or being drained this cycle.
    assign ld = !fvalid_q || iFieldReady;

    assign oField      = field_q;
    assign oFieldLen   = len_q;
    assign oFieldValid = fvalid_q;
    assign oSubDone    = subdone_q;
    assign oFrameDone  = framedone_q;
    assign oError      = err_q;
    assign oBusy       = busy_q;
    assign oChanReady  = (state_q == S_CHPAR) && iChanValid;
    assign oDataReady  = iDataValid && ld &&
                         (state_q == S_WARMUP || state_q == S_COEF);

    assign ord_c   = (iOrder > MAXO) ? MAXO : iOrder;
    assign prec_c  = (iPrecision == 4'd0) ? 4'd1 :
                     (iPrecision > MAXP) ? MAXP : iPrecision;
    assign bad_par = (iOrder > MAXO) || (iPrecision == 4'd0);

    assign m1      = 5'(ord_q - 6'd1);
    assign sub_hdr = (ord_q == 6'd0) ? FIXED0_HDR : {2'b01, m1, 1'b0};
    assign prsh    = {prec_q - 4'd1, shift_q};

    always_comb begin
        coef_v = '0;
        for (int b = 0; b < CW; b++) begin
            if (b < int'(prec_q)) coef_v[b] = iData[b];
        end
    end

    always_comb begin
        case (state_q)
            S_SYNC0: hdr_byte = SYNC_WORD[15:8];
            S_SYNC1: hdr_byte = SYNC_WORD[7:0];
            S_BSSR:  hdr_byte = {bs_q, sr_q};
            S_CHSS:  hdr_byte = {ca_q, ss_q, 1'b0};
            S_FNUM:  hdr_byte = utf8_byte(fnum_q, nb_q, fidx_q);
            default: hdr_byte = 8'h00;
        endcase
    end

    flac_crc8 u_crc (
        .crc_in (crc_q),
        .byte_in(hdr_byte),
        .crc_out(crc_d)
    );

    always_comb begin
        emit    = 1'b0;
        field_d = '0;
        len_d   = BYTE_LEN;
        case (state_q)
            S_SYNC0, S_SYNC1, S_BSSR, S_CHSS, S_FNUM: begin
                emit    = ld;
                field_d = FIELD_W'(hdr_byte);
            end
            S_CRC8: begin
                emit    = ld;
                field_d = FIELD_W'(crc_q);
            end
            S_SUBHDR: begin
                emit    = ld;
                field_d = FIELD_W'(sub_hdr);
            end
            S_WARMUP: begin
                emit    = ld && iDataValid;
                field_d = FIELD_W'(iData);
                len_d   = SW_LEN;
            end
            S_PRSH: begin
                emit    = ld;
                field_d = FIELD_W'(prsh);
                len_d   = PRSH_LEN;
            end
            S_COEF: begin
                emit    = ld && iDataValid;
                field_d = coef_v;
                len_d   = {2'b00, prec_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q     <= S_IDLE;
            fnum_q      <= '0;
            bs_q        <= '0;
            sr_q        <= '0;
            ca_q        <= '0;
            ss_q        <= '0;
            nb_q        <= '0;
            fidx_q      <= '0;
            crc_q       <= '0;
            ord_q       <= '0;
            sidx_q      <= '0;
            prec_q      <= '0;
            shift_q     <= '0;
            chan_q      <= '0;
            field_q     <= '0;
            len_q       <= '0;
            fvalid_q    <= 1'b0;
            subdone_q   <= 1'b0;
            framedone_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            subdone_q   <= 1'b0;
            framedone_q <= 1'b0;
            err_q       <= 1'b0;
            if (emit) begin
                field_q  <= field_d;
                len_q    <= len_d;
                fvalid_q <= 1'b1;
            end else if (ld) begin
                fvalid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    // A start coinciding with the done pulse waits a cycle.
                    if (iStart && !framedone_q) begin
                        fnum_q  <= iFrameNum;
                        nb_q    <= utf8_nbytes(iFrameNum);
                        bs_q    <= iBsCode;
                        sr_q    <= iSrCode;
                        ca_q    <= iChanAssign;
                        ss_q    <= iSsCode;
                        fidx_q  <= '0;
                        crc_q   <= '0;
                        chan_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SYNC0;
                    end
                end
                S_SYNC0: if (emit) begin
                    crc_q   <= crc_d;
                    state_q <= S_SYNC1;
                end
                S_SYNC1: if (emit) begin
                    crc_q   <= crc_d;
                    state_q <= S_BSSR;
                end
                S_BSSR: if (emit) begin
                    crc_q   <= crc_d;
                    state_q <= S_CHSS;
                end
                S_CHSS: if (emit) begin
                    crc_q   <= crc_d;
                    state_q <= S_FNUM;
                end
                S_FNUM: if (emit) begin
                    crc_q  <= crc_d;
                    fidx_q <= fidx_q + 3'd1;
                    if (fidx_q == nb_q - 3'd1) state_q <= S_CRC8;
                end
                S_CRC8: if (emit) state_q <= S_CHPAR;
                S_CHPAR: if (iChanValid) begin
                    ord_q   <= ord_c;
                    prec_q  <= prec_c;
                    shift_q <= iShift;
                    err_q   <= bad_par;
                    state_q <= S_SUBHDR;
                end
                S_SUBHDR: if (emit) begin
                    sidx_q <= '0;
                    if (ord_q == 6'd0) begin
                        subdone_q <= 1'b1;
                        state_q   <= S_NEXT;
                    end else begin
                        state_q <= S_WARMUP;
                    end
                end
                S_WARMUP: if (emit) begin
                    sidx_q <= sidx_q + 6'd1;
                    if (sidx_q == ord_q - 6'd1) begin
                        sidx_q  <= '0;
                        state_q <= S_PRSH;
                    end
                end
                S_PRSH: if (emit) state_q <= S_COEF;
                S_COEF: if (emit) begin
                    sidx_q <= sidx_q + 6'd1;
                    if (sidx_q == ord_q - 6'd1) begin
                        subdone_q <= 1'b1;
                        state_q   <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (chan_q == LASTCH) begin
                        state_q <= S_DONE;
                    end else begin
                        chan_q  <= chan_q + 4'd1;
                        state_q <= S_CHPAR;
                    end
                end
                S_DONE: begin
                    framedone_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
